// File: rtl/demux_lane_router_if.sv
// demux_lane_router_if: stream-in / four-lane-out bundle for demux_lane_router.
// master = producer/consumer environment, slave = the router itself.
interface demux_lane_router_if #(
  parameter int DATA_W = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [1:0]            in_sel;
  logic                  rr_mode;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic [1:0]            lane_sel;
  logic [1:0]            rr_ptr;
  logic [7:0]            stall_count;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, lane_sel, rr_ptr, stall_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, lane_sel, rr_ptr, stall_count
  );
endinterface

// File: rtl/demux_lane_router.sv
// demux_lane_router: registered 1-to-4 lane router in front of the demux stage.
// Each lane is a one-entry holding register with its own valid/ready.
// Destination is in_sel (rr_mode=0) or an internal round-robin pointer (rr_mode=1).
// Define DEMUX_LANE_ROUTER_STATS_EN to build the saturating stall counter;
// otherwise stall_count is tied to zero.
module demux_lane_router #(
  parameter int DATA_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  demux_lane_router_if.slave bus
);
  typedef enum logic {LANE_EMPTY = 1'b0, LANE_FULL = 1'b1} lane_state_e;

  lane_state_e         lane_st_q [4];
  lane_state_e         lane_st_d [4];
  logic [DATA_W-1:0]   data_q [4];
  logic [DATA_W-1:0]   data_d [4];
  logic [1:0]          lane_sel_q, lane_sel_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          tgt;
  logic                in_ready;
  logic                accept;
  logic [3:0]          out_valid_w;
  logic [4*DATA_W-1:0] out_data_w;

  // Target lane and readiness; readiness looks only at the target lane, never at in_valid.
  always_comb begin
    tgt      = bus.rr_mode ? rr_ptr_q : bus.in_sel;
    in_ready = (lane_st_q[tgt] == LANE_EMPTY) | bus.out_ready[tgt];
    accept   = bus.in_valid & in_ready;
  end

  // Per-lane next state: a load takes priority so a draining lane is refilled in the same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_st_d[k] = lane_st_q[k];
      data_d[k]    = data_q[k];
      if (accept && (tgt == 2'(k))) begin
        lane_st_d[k] = LANE_FULL;
        data_d[k]    = bus.in_data;
      end else if (bus.out_ready[k]) begin
        lane_st_d[k] = LANE_EMPTY;
      end
    end
  end

  // Select and round-robin pointer only move on an accept; the pointer only in rr_mode.
  always_comb begin
    lane_sel_d = lane_sel_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      lane_sel_d = tgt;
      if (bus.rr_mode) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  // Lane state machines, data holding registers, select and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        lane_st_q[k] <= LANE_EMPTY;
        data_q[k]    <= '0;
      end
      lane_sel_q <= 2'd0;
      rr_ptr_q   <= 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        lane_st_q[k] <= lane_st_d[k];
        data_q[k]    <= data_d[k];
      end
      lane_sel_q <= lane_sel_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Flatten lane registers onto the output bus.
  always_comb begin
    out_valid_w = '0;
    out_data_w  = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid_w[k]                  = (lane_st_q[k] == LANE_FULL);
      out_data_w[k*DATA_W +: DATA_W]  = data_q[k];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.lane_sel  = lane_sel_q;
  assign bus.rr_ptr    = rr_ptr_q;

`ifdef DEMUX_LANE_ROUTER_STATS_EN
  logic [7:0] stall_q, stall_d;

  // Count cycles with a word waiting but not accepted; stick at 255.
  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && !in_ready && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 8'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = 8'd0;
`endif
endmodule

// File: tb/tb_demux_lane_router.sv
// tb_demux_lane_router: directed and random stimulus against a lane-level reference model.
module tb_demux_lane_router;
  localparam int DW = 1;
`ifdef DEMUX_LANE_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  demux_lane_router_if #(.DATA_W(DW)) bus ();
  demux_lane_router #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model: which lanes hold a word, what they hold, last lane, pointer, stalls.
  bit          m_full [4];
  logic [DW-1:0] m_data [4];
  int          m_sel;
  int          m_rr;
  int          m_stall;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end
    m_sel   = 0;
    m_rr    = 0;
    m_stall = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model on the edge, check outputs after.
  task automatic cycle(string tag);
    int t;
    bit rdy, acc;
    logic [31:0] ev, ed;
    #1;
    t   = bus.rr_mode ? m_rr : int'(bus.in_sel);
    rdy = !m_full[t] || bus.out_ready[t];
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    acc = bus.in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (STATS && bus.in_valid && !rdy && m_stall < 255) m_stall++;
      for (int k = 0; k < 4; k++)
        if (m_full[k] && bus.out_ready[k]) m_full[k] = 1'b0;
      if (acc) begin
        m_full[t] = 1'b1;
        m_data[t] = bus.in_data;
        m_sel     = t;
        if (bus.rr_mode) m_rr = (m_rr + 1) % 4;
      end
    end
    #1;
    ev = '0;
    ed = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = m_full[k];
      ed[k*DW +: DW] = m_data[k];
    end
    chk({tag, ".out_valid"}, 32'(bus.out_valid), ev);
    chk({tag, ".out_data"}, 32'(bus.out_data), ed);
    chk({tag, ".lane_sel"}, 32'(bus.lane_sel), 32'(m_sel));
    chk({tag, ".rr_ptr"}, 32'(bus.rr_ptr), 32'(m_rr));
    chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(m_stall));
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = 2'd0;
    bus.rr_mode  = 1'b0;
    bus.out_ready = 4'h0;
    model_reset();

    // Reset: first edge brings state out of X, then check reset values held.
    @(posedge clk);
    @(negedge clk);
    cycle("rst");
    cycle("rst");
    chk("rst.out_valid_lit", 32'(bus.out_valid), 32'h0);
    chk("rst.in_ready_lit", 32'(bus.in_ready), 32'h1);

    // Explicit routing to lanes 0..3 with every lane ready.
    rst           = 1'b0;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = 2'(i);
      cycle("expl");
      chk("expl.valid_lit", 32'(bus.out_valid), 32'(1 << i));
      chk("expl.sel_lit", 32'(bus.lane_sel), 32'(i));
    end
    bus.in_valid = 1'b0;
    cycle("idle");

    // Round-robin: six words visit lanes 0,1,2,3,0,1.
    bus.rr_mode  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = DW'($urandom);
      cycle("rr");
      chk("rr.valid_lit", 32'(bus.out_valid), 32'(1 << (i % 4)));
    end
    chk("rr.ptr_end", 32'(bus.rr_ptr), 32'd2);
    bus.in_valid = 1'b0;
    cycle("idle");

    // Back-pressure on lane 2.
    bus.rr_mode   = 1'b0;
    bus.in_sel    = 2'd2;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    cycle("bp_acc");
    bus.in_data = 1'b0;
    cycle("bp_stall");
    cycle("bp_stall");
    chk("bp.lane2_data", 32'(bus.out_data[2*DW +: DW]), 32'h1);
    chk("bp.stall_cnt", 32'(bus.stall_count), STATS ? 32'd2 : 32'd0);
    bus.out_ready = 4'b0100;
    cycle("bp_resume");
    chk("bp.resume0", 32'(bus.out_data[2*DW +: DW]), 32'h0);
    bus.in_data = 1'b1;
    cycle("bp_resume");
    chk("bp.resume1", 32'(bus.out_data[2*DW +: DW]), 32'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    cycle("idle");

    // Simultaneous drain and load on lane 1.
    bus.out_ready = 4'h0;
    bus.in_sel    = 2'd1;
    bus.in_data   = 1'b0;
    bus.in_valid  = 1'b1;
    cycle("dl_fill");
    bus.out_ready = 4'b0010;
    bus.in_data   = 1'b1;
    cycle("dl");
    chk("dl.valid1", 32'(bus.out_valid[1]), 32'h1);
    chk("dl.data1", 32'(bus.out_data[1*DW +: DW]), 32'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    cycle("idle");

    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = DW'($urandom);
      bus.in_sel    = 2'($urandom);
      bus.rr_mode   = 1'($urandom_range(0, 1));
      bus.out_ready = 4'($urandom);
      cycle("rnd");
    end
    rst = 1'b0;

    // Stall saturation with lanes 0 and 3 full, then reset mid-transfer.
    bus.rr_mode   = 1'b0;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 1'b1;
    bus.in_sel    = 2'd0;
    cycle("sat_fill");
    bus.in_sel = 2'd3;
    cycle("sat_fill");
    for (int i = 0; i < 300; i++) cycle("sat");
    chk("sat.stall_cnt", 32'(bus.stall_count), STATS ? 32'd255 : 32'd0);
    chk("sat.lanes03", 32'(bus.out_valid & 4'b1001), 32'h9);
    bus.in_sel = 2'd1;
    rst        = 1'b1;
    cycle("rst_mid");
    chk("rst_mid.out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_mid.out_data", 32'(bus.out_data), 32'h0);
    chk("rst_mid.lane_sel", 32'(bus.lane_sel), 32'h0);
    chk("rst_mid.rr_ptr", 32'(bus.rr_ptr), 32'h0);
    chk("rst_mid.stall", 32'(bus.stall_count), 32'h0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    cycle("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
